// File: rtl/set_time_pkg.sv
// Shared definitions for the set-time edit path: mode codes, FSM states,
// the default YYYY-MM-DD-HH-MM-SS-W field layout and a layout helper.
package set_time_pkg;

    localparam int NUM_FIELDS = 21;

    localparam logic [3:0] MODE_DISP   = 4'd0;
    localparam logic [3:0] MODE_EDIT   = 4'd1;
    localparam logic [3:0] MODE_COMMIT = 4'd2;

    // Nibble 20 is leftmost; separators sit at 16,13,10,7,4,1
    localparam logic [20:0] DEF_SEP_MASK  = 21'h12492;
    localparam logic [83:0] DEF_DIGIT_MAX = 84'h999901903902905905906;
    localparam logic [3:0]  DEF_SEP_CODE  = 4'hA;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    function automatic logic [4:0] high_editable(input logic [20:0] m);
        logic [4:0] r;
        r = 5'd0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (!m[i]) r = 5'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/set_time_editor_finder.sv
// Combinational cursor step: next non-separator index above (dir=1) or
// below (dir=0) the current one, wrapping around the 21 positions.
import set_time_pkg::*;

module next_field_finder (
    input  logic [4:0]  cur,
    input  logic        dir,
    input  logic [20:0] mask,
    output logic [4:0]  nxt
);

    logic found;
    int   idx;

    always_comb begin
        nxt   = cur;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_FIELDS; k++) begin
            idx = dir ? (int'(cur) + k) % NUM_FIELDS
                      : (int'(cur) + NUM_FIELDS - k) % NUM_FIELDS;
            if (!found && !mask[idx]) begin
                nxt   = 5'(idx);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/set_time_editor.sv
// Set-time edit controller: mirrors live time, lets the user walk a cursor
// over editable digits, bumps them within per-digit bounds, then commits.
import set_time_pkg::*;

module set_time_editor #(
    parameter logic [20:0] SEP_MASK       = DEF_SEP_MASK,
    parameter logic [83:0] DIGIT_MAX      = DEF_DIGIT_MAX,
    parameter logic [3:0]  SEP_CODE       = DEF_SEP_CODE,
    parameter int          TIMEOUT_CYCLES = 500_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [83:0] time_in,
    input  logic        btn_enter,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_up,
    input  logic        btn_down,
    output logic [3:0]  mode,
    output logic [4:0]  count,
    output logic [83:0] tmp1,
    output logic        commit
);

    localparam logic [4:0] HIGH_EDIT = high_editable(SEP_MASK);

    if (SEP_MASK == {NUM_FIELDS{1'b1}}) begin : g_bad_mask
        $error("SEP_MASK leaves no editable position");
    end

    state_t      state, state_nxt;
    logic [3:0]  mode_nxt;
    logic [4:0]  count_nxt;
    logic [83:0] tmp1_nxt;
    logic        commit_nxt;
    logic [31:0] timer, timer_nxt;
    logic [4:0]  step_idx;
    logic [6:0]  base;
    logic [3:0]  cur_nib, max_nib;
    logic        any_btn;

    function automatic logic [3:0] digit_up(input logic [3:0] v, input logic [3:0] mx);
        return (v >= mx) ? 4'd0 : v + 4'd1;
    endfunction

    // Out-of-range values (possible from live time) clamp to the max
    function automatic logic [3:0] digit_down(input logic [3:0] v, input logic [3:0] mx);
        if (v == 4'd0) return mx;
        if (v > mx)    return mx;
        return v - 4'd1;
    endfunction

    function automatic logic [83:0] fill_separators(input logic [83:0] b);
        logic [83:0] r;
        r = b;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (SEP_MASK[i]) r[4*i +: 4] = SEP_CODE;
        end
        return r;
    endfunction

    next_field_finder u_finder (
        .cur  (count),
        .dir  (btn_left),
        .mask (SEP_MASK),
        .nxt  (step_idx)
    );

    assign base    = {count, 2'b00};
    assign cur_nib = tmp1[base +: 4];
    assign max_nib = DIGIT_MAX[base +: 4];
    assign any_btn = btn_enter | btn_left | btn_right | btn_up | btn_down;

    always_comb begin
        state_nxt  = state;
        mode_nxt   = mode;
        count_nxt  = count;
        tmp1_nxt   = tmp1;
        commit_nxt = 1'b0;
        timer_nxt  = timer;
        case (state)
            IDLE: begin
                mode_nxt  = MODE_DISP;
                count_nxt = 5'd20;
                tmp1_nxt  = time_in;
                timer_nxt = '0;
                if (btn_enter) begin
                    state_nxt = EDIT;
                    mode_nxt  = MODE_EDIT;
                    count_nxt = HIGH_EDIT;
                    tmp1_nxt  = tmp1;
                end
            end
            EDIT: begin
                timer_nxt = any_btn ? '0 : timer + 32'd1;
                if (btn_enter) begin
                    state_nxt  = COMMIT;
                    mode_nxt   = MODE_COMMIT;
                    commit_nxt = 1'b1;
                    tmp1_nxt   = fill_separators(tmp1);
                end else if (btn_left || btn_right) begin
                    count_nxt = step_idx;
                end else if (btn_up) begin
                    tmp1_nxt[base +: 4] = digit_up(cur_nib, max_nib);
                end else if (btn_down) begin
                    tmp1_nxt[base +: 4] = digit_down(cur_nib, max_nib);
                end else if (timer == 32'(TIMEOUT_CYCLES - 1)) begin
                    // Idle too long: drop the edits and fall back to display
                    state_nxt = IDLE;
                    mode_nxt  = MODE_DISP;
                    count_nxt = 5'd20;
                    tmp1_nxt  = time_in;
                    timer_nxt = '0;
                end
            end
            COMMIT: begin
                state_nxt = IDLE;
                mode_nxt  = MODE_DISP;
                count_nxt = 5'd20;
                tmp1_nxt  = time_in;
                timer_nxt = '0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            mode   <= MODE_DISP;
            count  <= 5'd20;
            tmp1   <= '0;
            commit <= 1'b0;
            timer  <= '0;
        end else begin
            state  <= state_nxt;
            mode   <= mode_nxt;
            count  <= count_nxt;
            tmp1   <= tmp1_nxt;
            commit <= commit_nxt;
            timer  <= timer_nxt;
        end
    end

endmodule

// File: tb/tb_set_time_editor.sv
// Directed bench for set_time_editor: cursor walk, digit bounds, priority,
// commit separator fill, idle timeout and mid-edit reset.
module tb_set_time_editor;

    localparam logic [83:0] T0 = 84'h2024A12A25A13A45A30A3;
    localparam logic [83:0] T1 = 84'h123456789012345678901;
    localparam logic [20:0] MASK = 21'h12492;

    localparam logic [4:0] B_E = 5'b10000;
    localparam logic [4:0] B_L = 5'b01000;
    localparam logic [4:0] B_R = 5'b00100;
    localparam logic [4:0] B_U = 5'b00010;
    localparam logic [4:0] B_D = 5'b00001;

    typedef struct {
        logic [4:0] btn;
        logic [4:0] exp_count;
        int         chk_idx;
        logic [3:0] exp_nib;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [83:0] time_in;
    logic        btn_enter, btn_left, btn_right, btn_up, btn_down;
    logic [3:0]  mode;
    logic [4:0]  count;
    logic [83:0] tmp1;
    logic        commit;

    int nchecks = 0;
    int nerrors = 0;

    vec_t        vt[$];
    logic [83:0] exp_buf;

    set_time_editor #(.TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .time_in   (time_in),
        .btn_enter (btn_enter),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .mode      (mode),
        .count     (count),
        .tmp1      (tmp1),
        .commit    (commit)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [83:0] act, input logic [83:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] b);
        {btn_enter, btn_left, btn_right, btn_up, btn_down} = b;
        step();
        {btn_enter, btn_left, btn_right, btn_up, btn_down} = 5'b0;
    endtask

    function automatic logic [83:0] sep_fill(input logic [83:0] v);
        logic [83:0] r;
        r = v;
        for (int i = 0; i < 21; i++) if (MASK[i]) r[4*i +: 4] = 4'hA;
        return r;
    endfunction

    initial begin
        logic [83:0] e;
        int bad;
        rst_n = 1'b0;
        time_in = T0;
        {btn_enter, btn_left, btn_right, btn_up, btn_down} = 5'b0;

        // Cursor walk and digit edits over T0; exp_nib is hand-computed
        vt.push_back('{B_R, 5'd19, 19, 4'h0});
        vt.push_back('{B_R, 5'd18, 18, 4'h2});
        vt.push_back('{B_R, 5'd17, 17, 4'h4});
        vt.push_back('{B_R, 5'd15, 15, 4'h1});
        vt.push_back('{B_R, 5'd14, 14, 4'h2});
        vt.push_back('{B_U, 5'd14, 14, 4'h3});
        vt.push_back('{B_U, 5'd14, 14, 4'h4});
        vt.push_back('{B_U, 5'd14, 14, 4'h5});
        vt.push_back('{B_U, 5'd14, 14, 4'h6});
        vt.push_back('{B_U, 5'd14, 14, 4'h7});
        vt.push_back('{B_U, 5'd14, 14, 4'h8});
        vt.push_back('{B_U, 5'd14, 14, 4'h9});
        vt.push_back('{B_U, 5'd14, 14, 4'h0});
        vt.push_back('{B_D, 5'd14, 14, 4'h9});
        vt.push_back('{B_L, 5'd15, 15, 4'h1});
        vt.push_back('{B_L, 5'd17, 17, 4'h4});
        vt.push_back('{B_L, 5'd18, 18, 4'h2});
        vt.push_back('{B_L, 5'd19, 19, 4'h0});
        vt.push_back('{B_L, 5'd20, 20, 4'h2});
        vt.push_back('{B_L, 5'd0,  0,  4'h3});
        vt.push_back('{B_U, 5'd0,  0,  4'h4});
        vt.push_back('{B_U, 5'd0,  0,  4'h5});
        vt.push_back('{B_U, 5'd0,  0,  4'h6});
        vt.push_back('{B_U, 5'd0,  0,  4'h0});
        vt.push_back('{B_R, 5'd20, 20, 4'h2});
        vt.push_back('{B_R, 5'd19, 19, 4'h0});
        vt.push_back('{B_R, 5'd18, 18, 4'h2});
        vt.push_back('{B_R, 5'd17, 17, 4'h4});
        vt.push_back('{B_R, 5'd15, 15, 4'h1});
        vt.push_back('{B_U, 5'd15, 15, 4'h0});
        vt.push_back('{B_D, 5'd15, 15, 4'h1});
        vt.push_back('{B_L | B_U, 5'd17, 15, 4'h1});

        step();
        check("reset mode", 84'(mode), 84'd0);
        check("reset count", 84'(count), 84'd20);
        check("reset tmp1", tmp1, 84'd0);
        check("reset commit", 84'(commit), 84'd0);

        rst_n = 1'b1;
        step();
        step();
        check("idle tmp1", tmp1, T0);
        check("idle mode", 84'(mode), 84'd0);
        check("idle count", 84'(count), 84'd20);
        check("idle commit", 84'(commit), 84'd0);

        press(B_E);
        check("enter mode", 84'(mode), 84'd1);
        check("enter count", 84'(count), 84'd20);
        check("enter tmp1", tmp1, T0);
        time_in = T1;

        exp_buf = T0;
        for (int i = 0; i < vt.size(); i++) begin
            press(vt[i].btn);
            exp_buf[4*vt[i].chk_idx +: 4] = vt[i].exp_nib;
            check($sformatf("vec%0d mode", i), 84'(mode), 84'd1);
            check($sformatf("vec%0d count", i), 84'(count), 84'(vt[i].exp_count));
            check($sformatf("vec%0d nibble", i), 84'(tmp1[4*vt[i].chk_idx +: 4]), 84'(vt[i].exp_nib));
        end
        check("frozen buffer", tmp1, exp_buf);

        // enter wins over down; nibble 17 must stay 4
        press(B_E | B_D);
        check("commit mode", 84'(mode), 84'd2);
        check("commit pulse", 84'(commit), 84'd1);
        check("commit tmp1", tmp1, sep_fill(exp_buf));
        step();
        check("post commit mode", 84'(mode), 84'd0);
        check("post commit pulse", 84'(commit), 84'd0);
        check("post commit count", 84'(count), 84'd20);
        check("post commit tmp1", tmp1, T1);

        // Second session: separators of T1 are not A, so forcing is visible
        press(B_E);
        press(B_U);
        e = T1;
        e[83:80] = 4'h2;
        check("s2 up", tmp1, e);
        press(B_E);
        check("s2 commit pulse", 84'(commit), 84'd1);
        check("s2 commit tmp1", tmp1, sep_fill(e));
        step();
        check("s2 pulse width", 84'(commit), 84'd0);

        // Idle timeout after one edit
        press(B_E);
        press(B_U);
        bad = 0;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (commit !== 1'b0) bad++;
        end
        check("timeout no commit", 84'(bad), 84'd0);
        check("timeout still edit", 84'(mode), 84'd1);
        step();
        check("timeout mode", 84'(mode), 84'd0);
        check("timeout commit", 84'(commit), 84'd0);
        check("timeout count", 84'(count), 84'd20);
        check("timeout tmp1", tmp1, T1);

        // Reset in the middle of an edit
        press(B_E);
        press(B_R);
        press(B_U);
        rst_n = 1'b0;
        step();
        check("midreset mode", 84'(mode), 84'd0);
        check("midreset count", 84'(count), 84'd20);
        check("midreset tmp1", tmp1, 84'd0);
        check("midreset commit", 84'(commit), 84'd0);
        rst_n = 1'b1;
        step();
        step();
        check("after reset tmp1", tmp1, T1);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
